// File: rtl/mux_n_reg.sv
// mux_n_reg: N-channel, W-bit multiplexer with a registered output stage.
// Each channel and the consumer use a valid/ready handshake. The channel is
// picked either by an explicit index (mode=0, sel) or by round-robin among
// the channels that are requesting (mode=1).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_data            CHANNELS words, channel c at [c*WIDTH +: WIDTH]
//   in_valid/in_ready  per-channel handshake; in_ready is one-hot or zero
//   mode, sel          0: use channel sel, 1: round-robin
//   out_data/out_chan  registered word and the channel it came from
//   out_valid/out_ready  output handshake

// Per-channel slice: raises ready when this channel holds the grant and
// passes its word through. Words from channels without the grant are zeroed,
// so the top can OR all lanes together.
module mux_n_reg_lane #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [WIDTH-1:0] data,
  input  logic             take,
  input  logic [SEL_W-1:0] gnt_idx,
  output logic             ready,
  output logic [WIDTH-1:0] word
);
  assign ready = take && (gnt_idx == SEL_W'(IDX));
  assign word  = ready ? data : '0;
endmodule

module mux_n_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic                             free;
  logic [SEL_W-1:0]                 last_grant;
  logic                             gnt_any;
  logic [SEL_W-1:0]                 gnt_idx;
  logic                             take;
  logic [CHANNELS-1:0][WIDTH-1:0]   lane_word;
  logic [WIDTH-1:0]                 sel_word;

  // The register can take a new word when it is empty or when its current
  // word leaves on this edge.
  assign free = !out_valid || out_ready;

  // Grant search. In round-robin mode the scan starts just after the last
  // granted channel and wraps, so the winner is the first requester in that
  // order.
  always_comb begin
    int c;
    gnt_any = 1'b0;
    gnt_idx = '0;
    c       = 0;
    if (!mode) begin
      if (int'(sel) < CHANNELS && in_valid[sel]) begin
        gnt_any = 1'b1;
        gnt_idx = sel;
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        c = int'(last_grant) + k;
        if (c >= CHANNELS) c = c - CHANNELS;
        if (!gnt_any && in_valid[SEL_W'(c)]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(c);
        end
      end
    end
  end

  // Reset also gates the grant, so in_ready stays low while rst_n is asserted.
  assign take = gnt_any && free && rst_n;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    mux_n_reg_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(g)) u_lane (
      .data    (in_data[g*WIDTH +: WIDTH]),
      .take    (take),
      .gnt_idx (gnt_idx),
      .ready   (in_ready[g]),
      .word    (lane_word[g])
    );
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < CHANNELS; k++) sel_word = sel_word | lane_word[k];
  end

  // The reset value of last_grant is the top channel, so the first
  // round-robin pass starts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_chan   <= '0;
      out_valid  <= 1'b0;
      last_grant <= SEL_W'(CHANNELS - 1);
    end else if (free) begin
      if (take) begin
        out_data   <= sel_word;
        out_chan   <= gnt_idx;
        out_valid  <= 1'b1;
        last_grant <= gnt_idx;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_n_reg.sv
module tb_mux_n_reg;
  localparam int W  = 16;
  localparam int C  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_valid, in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid, out_ready;

  logic [1:0] b_data, b_valid, b_ready;
  logic       b_mode, b_sel, b_out_data, b_out_chan, b_out_valid, b_out_ready;

  mux_n_reg #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready));

  mux_n_reg #(.WIDTH(1), .CHANNELS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
    .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready));

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [W-1:0] d; logic [SW-1:0] ch; } exp_t;
  exp_t sb[$];

  // Reference model state: is a word held, and who was granted last.
  bit m_valid;
  int m_last;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_valid = 0;
    m_last  = C - 1;
  endtask

  // Evaluated between edges with the current inputs: predicts the grant,
  // checks in_ready/out_valid, and queues the word the next edge must load.
  task automatic model_step();
    bit free;
    int g;
    logic [C-1:0] exp_rdy;
    free = !m_valid || out_ready;
    g = -1;
    if (free) begin
      if (mode == 1'b0) begin
        if (int'(sel) < C && in_valid[sel]) g = int'(sel);
      end else begin
        for (int k = 1; k <= C; k++) begin
          int c = (m_last + k) % C;
          if (g < 0 && in_valid[c]) g = c;
        end
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_valid);
    if (free) begin
      if (g >= 0) begin
        m_valid = 1;
        m_last  = g;
        sb.push_back({in_data[g*W +: W], SW'(g)});
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any word on the output must equal the queue head, every cycle
  // it is shown (so stalled words must stay put); popped when consumed.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got word %0h ch %0d with nothing expected", out_data, out_chan);
      end else begin
        chk("out_data", out_data, sb[0].d);
        chk("out_chan", out_chan, sb[0].ch);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_chan"}, out_chan, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    logic [C*W-1:0] fixed_data;
    logic [7:0] tbl;
    fixed_data = {16'hD000, 16'h0C00, 16'h00B0, 16'h000A};
    tbl = 8'b1101_1000;

    rst_n = 1'b0;
    in_data = {$urandom, $urandom};
    in_valid = '1;
    mode = 1'b1;
    sel = '0;
    out_ready = 1'b1;
    b_data = '0; b_valid = '0; b_mode = 1'b0; b_sel = 1'b0; b_out_ready = 1'b1;
    model_reset();

    // Reset held with every channel requesting.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();
    chk("first_rr_chan", out_chan, 0);

    // Fixed select walks sel 0..3.
    in_data = fixed_data;
    mode = 1'b0;
    for (int s = 0; s < C; s++) begin
      sel = SW'(s);
      step();
      chk("fixed_data", out_data, fixed_data[s*W +: W]);
    end

    // Round-robin over all channels, then over channels 1 and 3.
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_all", out_chan, i % C);
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_1010", out_chan, (i % 2 == 0) ? 1 : 3);
    end

    // Backpressure with a held word 00B0.
    in_valid = '1;
    in_data = fixed_data;
    mode = 1'b0;
    sel = 2'd1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      step();
      chk("stall_data", out_data, 16'h00B0);
      chk("stall_chan", out_chan, 1);
    end
    out_ready = 1'b1;
    step();

    // Fixed select on an idle channel: the word drains, then nothing.
    sel = 2'd3;
    in_valid = 4'b0111;
    step();
    step();
    chk("no_grant_valid", out_valid, 0);

    // Asynchronous reset in the middle of a stall.
    in_valid = '1;
    sel = 2'd2;
    step();
    out_ready = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    model_reset();
    #1 rst_n = 1'b1;
    mode = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_reset_rr", out_chan, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_data = {$urandom, $urandom};
      in_valid = C'($urandom);
      mode = 1'($urandom);
      sel = SW'($urandom);
      out_ready = ($urandom_range(3) != 0);
      step();
    end

    // Drain; every predicted word must have been seen.
    in_valid = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("sb_drain", sb.size(), 0);

    // 2:1 compatibility on the two-channel, one-bit instance.
    b_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      b_data = {v[1], v[2]};
      b_sel = v[0];
      @(negedge clk);
      chk("mux2_ready", b_ready, v[0] ? 2'b10 : 2'b01);
      @(posedge clk);
      #1;
      chk("mux2_data", b_out_data, tbl[i]);
      chk("mux2_chan", b_out_chan, v[0]);
      chk("mux2_valid", b_out_valid, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
